// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, bubble instruction, fetch FSM encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package if_stage_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] IF_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // Fetch FSM encoding, kept as plain constants for legacy tool flows.
  localparam logic [1:0] FS_IDLE = 2'd0;  // free to issue a request
  localparam logic [1:0] FS_WAIT = 2'd1;  // granted, waiting for the response
  localparam logic [1:0] FS_DROP = 2'd2;  // waiting for a stale response to discard

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid.sv
// One-entry {pc, inst} holding register used while decode is stalled.
// Latency: loaded entry is visible on o_entry/o_valid the cycle after i_load.
// Backpressure: clear has priority over load, load over pop; caller never loads a full entry.
module if_skid
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   i_load,
  input  logic   i_pop,
  input  logic   i_clear,
  input  fetch_t i_entry,
  output fetch_t o_entry,
  output logic   o_valid
);

  fetch_t r_entry;
  logic   r_valid;

  // Occupancy flag: clear beats load, load beats pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  // Payload captured only on load; stale contents are harmless once r_valid drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_entry <= '{pc: 32'h0, inst: NOP_INST};
    end else if (i_load && !i_clear) begin
      r_entry <= i_entry;
    end
  end

  assign o_entry = r_entry;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem port, IF/ID register; optional IF_PERF_EN counters.
// Latency: grant in t, rvalid in t+1, instruction on id_*_o in t+2 (1 instr / 2 cycles).
// Backpressure: stall_i holds IF/ID, a response arriving under stall parks in the skid and blocks new requests.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter logic [31:0] NOP_INST = IF_NOP_INST
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        wfi_i,
  input  logic        wake_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_gnt_i,
  input  logic        im_rvalid_i,
  input  logic [31:0] im_rdata_i,
`ifdef IF_PERF_EN
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_drop_o,
`endif
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_sleep_q;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  logic        w_skid_v;
  fetch_t      w_skid_entry;
  logic        w_gnt;
  logic        w_rsp_wait;
  logic        w_accept;
  logic        w_discard;
  logic        w_deliver;
  logic        w_skid_load;
  logic        w_skid_pop;

  // Requests only from IDLE with an empty skid and not asleep; masked during reset.
  assign im_req_o  = (r_state == FS_IDLE) & ~w_skid_v & ~r_sleep_q & rst_ni;
  assign im_addr_o = r_pc;
  assign w_gnt     = im_req_o & im_gnt_i;

  // Response outcomes: accepted (to IF/ID or skid) or discarded as stale.
  assign w_rsp_wait  = (r_state == FS_WAIT) & im_rvalid_i;
  assign w_accept    = w_rsp_wait & ~flush_i;
  assign w_discard   = (w_rsp_wait & flush_i) | ((r_state == FS_DROP) & im_rvalid_i);
  assign w_deliver   = w_accept & ~stall_i;
  assign w_skid_load = w_accept & stall_i;
  assign w_skid_pop  = ~flush_i & ~stall_i & w_skid_v;

  if_skid #(
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_load  (w_skid_load),
    .i_pop   (w_skid_pop),
    .i_clear (flush_i),
    .i_entry ('{pc: r_pc, inst: im_rdata_i}),
    .o_entry (w_skid_entry),
    .o_valid (w_skid_v)
  );

  // Fetch FSM and PC: a flush always redirects, an accepted response advances by 4.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= FS_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (w_gnt) begin
            r_state <= flush_i ? FS_DROP : FS_WAIT;
          end
          if (flush_i) begin
            r_pc <= redirect_pc_i;
          end
        end
        FS_WAIT: begin
          if (flush_i) begin
            r_pc    <= redirect_pc_i;
            r_state <= im_rvalid_i ? FS_IDLE : FS_DROP;
          end else if (im_rvalid_i) begin
            r_pc    <= pc_incr(r_pc);
            r_state <= FS_IDLE;
          end
        end
        FS_DROP: begin
          if (im_rvalid_i) begin
            r_state <= FS_IDLE;
          end
          if (flush_i) begin
            r_pc <= redirect_pc_i;
          end
        end
        default: begin
          r_state <= FS_IDLE;
        end
      endcase
    end
  end

  // Sleep flag: wake dominates a simultaneous wfi.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sleep_q <= 1'b0;
    end else if (wake_i) begin
      r_sleep_q <= 1'b0;
    end else if (wfi_i) begin
      r_sleep_q <= 1'b1;
    end
  end

  // IF/ID register: flush > stall > skid > fresh response > bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id_pc    <= 32'h0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (flush_i) begin
      r_id_pc    <= 32'h0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else if (stall_i) begin
      r_id_pc    <= r_id_pc;
      r_id_inst  <= r_id_inst;
      r_id_valid <= r_id_valid;
    end else if (w_skid_v) begin
      r_id_pc    <= w_skid_entry.pc;
      r_id_inst  <= w_skid_entry.inst;
      r_id_valid <= 1'b1;
    end else if (w_deliver) begin
      r_id_pc    <= r_pc;
      r_id_inst  <= im_rdata_i;
      r_id_valid <= 1'b1;
    end else begin
      r_id_pc    <= 32'h0;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end
  end

  assign id_pc_o    = r_id_pc;
  assign id_inst_o  = r_id_inst;
  assign id_valid_o = r_id_valid;

`ifdef IF_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_drop;

  // Event counters for accepted and discarded responses; wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_fetch <= 32'h0;
      r_perf_drop  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_perf_fetch <= r_perf_fetch + 32'd1;
      end
      if (w_discard) begin
        r_perf_drop <= r_perf_drop + 32'd1;
      end
    end
  end

  assign perf_fetch_o = r_perf_fetch;
  assign perf_drop_o  = r_perf_drop;
`else
  // Discard tracking only feeds the optional counters.
  logic w_unused;
  assign w_unused = w_discard;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small instruction-memory model (rdata = addr ^ 32'hA5A5_0000).
// Stimulus and checks on the falling edge; the memory model acts 2 time units later.
// Optional IF_PERF_EN counters are checked when the macro is defined.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i, flush_i, wfi_i, wake_i;
  logic [31:0] redirect_pc_i;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        im_gnt_i;
  logic        im_rvalid_i;
  logic [31:0] im_rdata_i;
  logic [31:0] id_pc_o, id_inst_o;
  logic        id_valid_o;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_o, perf_drop_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Memory model state
  bit          m_gnt_en;
  int          m_delay;
  bit          m_pend;
  int          m_cnt;
  logic [31:0] m_addr;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  always #5 clk_i = ~clk_i;

  if_stage dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .wfi_i         (wfi_i),
    .wake_i        (wake_i),
    .im_req_o      (im_req_o),
    .im_addr_o     (im_addr_o),
    .im_gnt_i      (im_gnt_i),
    .im_rvalid_i   (im_rvalid_i),
    .im_rdata_i    (im_rdata_i),
`ifdef IF_PERF_EN
    .perf_fetch_o  (perf_fetch_o),
    .perf_drop_o   (perf_drop_o),
`endif
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_valid_o    (id_valid_o)
  );

  assign im_gnt_i = im_req_o & m_gnt_en;

  // Memory: a grant seen in cycle t yields rvalid in cycle t+m_delay.
  always @(negedge clk_i) begin
    #2;
    im_rvalid_i = 1'b0;
    if (!rst_ni) begin
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          im_rvalid_i = 1'b1;
          im_rdata_i  = m_addr ^ XK;
          m_pend      = 1'b0;
        end
      end
      if (im_req_o && im_gnt_i) begin
        m_pend = 1'b1;
        m_addr = im_addr_o;
        m_cnt  = m_delay;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b0; stall_i = 1'b0; flush_i = 1'b0; wfi_i = 1'b0; wake_i = 1'b0;
    redirect_pc_i = 32'h0; im_rvalid_i = 1'b0; im_rdata_i = 32'h0;
    m_gnt_en = 1'b1; m_delay = 1; m_pend = 1'b0; m_cnt = 0; m_addr = 32'h0;

    // t=10: reset asserted
    cyc();
    chk("rst_req",   {31'h0, im_req_o},   32'h0);
    chk("rst_addr",  im_addr_o,           32'h0);
    chk("rst_pc",    id_pc_o,             32'h0);
    chk("rst_inst",  id_inst_o,           NOP);
    chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
`ifdef IF_PERF_EN
    chk("rst_pf", perf_fetch_o, 32'h0);
    chk("rst_pd", perf_drop_o,  32'h0);
`endif
    cyc();
    cyc();  // t=30: release; first request granted this cycle
    rst_ni = 1'b1;

    // Zero-wait stream: 0, 4, 8 every second cycle
    cyc();  // t=40 WAIT
    chk("s0_req",   {31'h0, im_req_o},   32'h0);
    chk("s0_valid", {31'h0, id_valid_o}, 32'h0);
    cyc();  // t=50 pc0 delivered
    chk("s1_pc",    id_pc_o,             32'h0);
    chk("s1_inst",  id_inst_o,           XK);
    chk("s1_valid", {31'h0, id_valid_o}, 32'h1);
    chk("s1_addr",  im_addr_o,           32'h4);
    cyc();  // t=60 bubble
    chk("s2_valid", {31'h0, id_valid_o}, 32'h0);
    chk("s2_inst",  id_inst_o,           NOP);
    cyc();  // t=70 pc4 delivered
    chk("s3_pc",    id_pc_o,             32'h4);
    chk("s3_valid", {31'h0, id_valid_o}, 32'h1);
    chk("s3_req",   {31'h0, im_req_o},   32'h1);
    chk("s3_addr",  im_addr_o,           32'h8);

    // Stall across the response for PC 8
    stall_i = 1'b1;
    cyc();  // t=80 hold pc4, WAIT
    chk("st0_pc", id_pc_o, 32'h4);
    cyc();  // t=90 response parked in skid
    chk("st1_pc",    id_pc_o,             32'h4);
    chk("st1_valid", {31'h0, id_valid_o}, 32'h1);
    chk("st1_req",   {31'h0, im_req_o},   32'h0);
    chk("st1_addr",  im_addr_o,           32'hC);
    stall_i = 1'b0;
    cyc();  // t=100 skid drained
    chk("st2_pc",    id_pc_o,             32'h8);
    chk("st2_inst",  id_inst_o,           32'hA5A5_0008);
    chk("st2_valid", {31'h0, id_valid_o}, 32'h1);
    chk("st2_req",   {31'h0, im_req_o},   32'h1);
    chk("st2_addr",  im_addr_o,           32'hC);

    // Flush in WAIT with a 3-cycle response
    m_delay = 3;
    cyc();  // t=110 WAIT
    flush_i = 1'b1; redirect_pc_i = 32'h100;
    cyc();  // t=120 DROP
    flush_i = 1'b0;
    chk("fw0_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fw0_req",   {31'h0, im_req_o},   32'h0);
    chk("fw0_addr",  im_addr_o,           32'h100);
    cyc();  // t=130 still DROP
    chk("fw1_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fw1_req",   {31'h0, im_req_o},   32'h0);
    cyc();  // t=140 stale dropped
    m_delay = 1;
    chk("fw2_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fw2_inst",  id_inst_o,           NOP);
    chk("fw2_req",   {31'h0, im_req_o},   32'h1);
    chk("fw2_addr",  im_addr_o,           32'h100);
`ifdef IF_PERF_EN
    chk("fw2_pd", perf_drop_o, 32'h1);
`endif
    cyc();
    cyc();  // t=160 pc 0x100 delivered
    chk("fw3_pc",    id_pc_o,             32'h100);
    chk("fw3_inst",  id_inst_o,           32'hA5A5_0100);
    chk("fw3_valid", {31'h0, id_valid_o}, 32'h1);
`ifdef IF_PERF_EN
    chk("fw3_pf", perf_fetch_o, 32'h4);
`endif

    // Flush together with grant in IDLE
    flush_i = 1'b1; redirect_pc_i = 32'h200;
    cyc();  // t=170 DROP
    flush_i = 1'b0;
    chk("fg0_req",   {31'h0, im_req_o},   32'h0);
    chk("fg0_addr",  im_addr_o,           32'h200);
    chk("fg0_valid", {31'h0, id_valid_o}, 32'h0);
    cyc();  // t=180 stale dropped
    chk("fg1_req",   {31'h0, im_req_o},   32'h1);
    chk("fg1_valid", {31'h0, id_valid_o}, 32'h0);
`ifdef IF_PERF_EN
    chk("fg1_pd", perf_drop_o, 32'h2);
`endif

    // WFI with redirect to 0x40, then wake
    m_gnt_en = 1'b0;
    wfi_i = 1'b1; flush_i = 1'b1; redirect_pc_i = 32'h40;
    cyc();  // t=190 asleep
    wfi_i = 1'b0; flush_i = 1'b0; m_gnt_en = 1'b1;
    chk("sl_addr", im_addr_o, 32'h40);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("sl_req%0d", i), {31'h0, im_req_o}, 32'h0);
      cyc();
    end
    wake_i = 1'b1;  // t=290
    cyc();  // t=300 awake, request issued
    wake_i = 1'b0;
    chk("wk_req",  {31'h0, im_req_o}, 32'h1);
    chk("wk_addr", im_addr_o,         32'h40);
    cyc();
    cyc();  // t=320 pc 0x40 delivered
    chk("wk_pc",    id_pc_o,             32'h40);
    chk("wk_inst",  id_inst_o,           32'hA5A5_0040);
    chk("wk_valid", {31'h0, id_valid_o}, 32'h1);

    // Fill the skid, then flush+stall together
    stall_i = 1'b1;
    cyc();  // t=330 WAIT for 0x44
    cyc();  // t=340 skid holds 0x44
    chk("fs0_req", {31'h0, im_req_o}, 32'h0);
    chk("fs0_pc",  id_pc_o,           32'h40);
    flush_i = 1'b1; redirect_pc_i = 32'h80;
    cyc();  // t=350
    flush_i = 1'b0; stall_i = 1'b0;
    chk("fs1_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fs1_inst",  id_inst_o,           NOP);
    chk("fs1_req",   {31'h0, im_req_o},   32'h1);
    chk("fs1_addr",  im_addr_o,           32'h80);
    cyc();  // t=360 skid entry must not reappear
    chk("fs2_valid", {31'h0, id_valid_o}, 32'h0);
    chk("fs2_pc",    id_pc_o,             32'h0);
    cyc();  // t=370 pc 0x80 delivered
    chk("fs3_pc",    id_pc_o,             32'h80);
    chk("fs3_inst",  id_inst_o,           32'hA5A5_0080);
    chk("fs3_valid", {31'h0, id_valid_o}, 32'h1);
`ifdef IF_PERF_EN
    chk("fs3_pf", perf_fetch_o, 32'h7);
    chk("fs3_pd", perf_drop_o,  32'h2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
